barrel_shift_arbiter: RTL and testbench
=======================================

Name: barrel_shift_arbiter

Overview:
Round-robin scheduler that time-shares one barrel_shifter_8bit instance (in[7:0], ctrl[2:0], out[7:0]) among NREQ requesters.
- Each requester presents an operand and shift amount with a valid/ready handshake.
- The arbiter registers the winner's operands onto the shifter, captures the result one cycle later, and returns it with the requester ID on a single response channel.
- Sits between the requesting engines and the shared shifter; the shifter stays combinational and outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand/result width (matches shifter)
SW, 3, shift-amount width (matches shifter ctrl)
IDW, 2, requester ID width, must be at least clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_data  in  NREQ*DW  packed operands, requester i at [i*DW +: DW]
req_shamt  in  NREQ*SW  packed shift amounts, requester i at [i*SW +: SW]
bs_in  out  DW  to shifter in, registered
bs_ctrl  out  SW  to shifter ctrl, registered
bs_out  in  DW  from shifter out
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  DW  shifted result
rsp_id  out  IDW  index of the requester that issued it

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=0, bs_in=0, bs_ctrl=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr pointer=NREQ-1 (requester 0 wins first).
- IDLE state:
  - winner = first i with req_valid[i]=1, searching from (ptr+1) mod NREQ upward and wrapping.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On that edge: bs_in<=req_data[winner], bs_ctrl<=req_shamt[winner], id reg<=winner, ptr<=winner, next state EXEC.
  - No valid requests: stay IDLE with req_ready=0.
- EXEC state: one cycle. rsp_data<=bs_out, rsp_id<=id reg, rsp_valid<=1, next state RESP.
- RESP state:
  - rsp_valid=1 and rsp_data/rsp_id stay stable until rsp_ready=1.
  - On that edge: rsp_valid<=0, next state IDLE.
  - req_ready=0 throughout.
- Timing: latency is 2 cycles from accept edge to rsp_valid high. Peak throughput is 1 op per 3 cycles with rsp_ready held high.
- bs_in and bs_ctrl hold their last values outside EXEC (no glitching to 0).
- Requester protocol: a requester must hold req_valid, req_data and req_shamt until accepted. Deasserting valid before acceptance is legal and simply withdraws the request.
- Simultaneous requests: exactly one is granted. The last-granted requester has lowest priority next time.
- Wrap-around: ptr=NREQ-1 searches from 0.
- Single active requester: it wins every IDLE cycle.
- Reset asserted mid-operation: immediate return to reset values; any in-flight result is discarded; no response is emitted.
- Shift amount: passed unmodified. Direction and rotate-vs-shift semantics belong to the shifter. shamt=0 is legal.

Optional Feature:
Macro: BS_ARB_ZERO_BYPASS_EN.
- Defined: an IDLE grant with shamt==0 skips EXEC. It loads rsp_data<=req_data[winner], rsp_id<=winner, rsp_valid<=1 and goes straight to RESP, giving latency 1. bs_in and bs_ctrl are not updated for that op.
- Undefined: every request, including shamt==0, goes through EXEC with latency 2.
- Arbitration order is identical in both builds.

Decomposition:
- Shared header barrel_shift_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - default DW=8 and SW=3 constants, reused by the shifter and its benches.
- Sub-module rr_arbiter (NREQ): combinational round-robin picker. Inputs: req vector and pointer. Outputs: one-hot grant and encoded index.
- FSM and datapath registers stay in barrel_shift_arbiter.

Test Plan:
Every case uses a bench that instantiates barrel_shifter_8bit on the bs_* ports. Expected rsp_data is bs_out for the issued (bs_in, bs_ctrl).
- Single request, req 0: req_data=8'h80, shamt=4, rsp_ready=1 -> req_ready[0] pulses 1 cycle; next cycle bs_in=8'h80, bs_ctrl=3'd4; rsp_valid after 2 cycles with rsp_id=0 and rsp_data = shifter out for (8'h80,4); rsp_valid drops the cycle after.
- All 4 requesters valid continuously, data 8'h01..8'h04, shamt 1..4 -> grant order 0,1,2,3,0 and rsp_id sequence matches; one response every 3 cycles.
- Backpressure, rsp_ready=0 for 5 cycles with req 2 (8'hFF, shamt 7) -> rsp_valid held with rsp_data and rsp_id=2 stable; no req_ready during the stall; completes on the first rsp_ready=1 edge.
- Reset mid-op: rst_n low during EXEC -> all outputs at reset values within the same cycle; after release, a pending req 0 is granted first.
- Zero shift, req 1: 8'h5A, shamt=0 -> rsp_data=8'h5A, rsp_id=1. Latency 1 with BS_ARB_ZERO_BYPASS_EN defined, latency 2 without.

Source files
------------

// File: rtl/barrel_shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// barrel_shift_arbiter_pkg
// Shared definitions for the barrel-shifter arbitration slice.
//   state_t : arbiter FSM encoding (IDLE=0, EXEC=1, RESP=2)
//   BS_DW   : default operand/result width of the shared shifter
//   BS_SW   : default shift-amount width of the shared shifter
// -----------------------------------------------------------------------------
package barrel_shift_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int BS_DW = 8;
  localparam int BS_SW = 3;

endpackage

// File: rtl/barrel_shift_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts one position after the
// pointer and wraps, so the last-granted requester has the lowest priority.
// Ports:
//   req   [NREQ-1:0] : request vector
//   ptr   [IDW-1:0]  : index of the last-granted requester
//   grant [NREQ-1:0] : one-hot grant (zero when no request)
//   idx   [IDW-1:0]  : encoded index of the granted requester
//   any              : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Offsets 1..NREQ visit every requester once, ending at the pointer itself.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = IDW'(cand);
      end
    end
    if (any) grant = NREQ'(1) << idx;
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// -----------------------------------------------------------------------------
// barrel_shift_arbiter
// Round-robin scheduler time-sharing one external combinational barrel shifter
// among NREQ requesters. A grant registers the winner's operands onto the
// shifter (bs_in/bs_ctrl), the shifter result is captured one cycle later and
// returned on a single valid/ready response channel together with the ID.
//
// Optional build macro:
//   BS_ARB_ZERO_BYPASS_EN : a grant with shamt==0 skips the shifter and
//                           loads the response directly (latency 1).
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   req_valid/req_ready     : per-requester handshake, ready is one-hot or 0
//   req_data  [NREQ*DW-1:0] : packed operands, requester i at [i*DW +: DW]
//   req_shamt [NREQ*SW-1:0] : packed shift amounts, requester i at [i*SW +: SW]
//   bs_in, bs_ctrl          : registered operands to the shared shifter
//   bs_out                  : shifter result
//   rsp_valid/rsp_ready     : response handshake
//   rsp_data, rsp_id        : shifted result and issuing requester index
// -----------------------------------------------------------------------------
module barrel_shift_arbiter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = BS_DW,
  parameter int SW   = BS_SW,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*SW-1:0] req_shamt,
  output logic [DW-1:0]     bs_in,
  output logic [SW-1:0]     bs_ctrl,
  input  logic [DW-1:0]     bs_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [IDW-1:0]    rsp_id
);

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_p1;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [DW-1:0]   win_data;
  logic [SW-1:0]   win_shamt;
  logic            bypass;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    win_data  = req_data[int'(win_idx)*DW +: DW];
    win_shamt = req_shamt[int'(win_idx)*SW +: SW];
  end

`ifdef BS_ARB_ZERO_BYPASS_EN
  // A zero shift is an identity, so the shifter round trip can be skipped.
  assign bypass = (win_shamt == '0);
`else
  assign bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_any) state_d = bypass ? ST_RESP : ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: grants are only offered while idle
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE) req_ready = grant;
  end

  // Datapath registers. bs_in/bs_ctrl are only written on a shifter grant so
  // the shifter inputs never glitch between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs_in     <= '0;
      bs_ctrl   <= '0;
      id_p1     <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state_q)
        // Stage p0 -> p1: winner operands onto the shifter
        ST_IDLE: begin
          if (win_any) begin
            ptr_q <= win_idx;
            id_p1 <= win_idx;
            if (bypass) begin
              rsp_data  <= win_data;
              rsp_id    <= win_idx;
              rsp_valid <= 1'b1;
            end else begin
              bs_in   <= win_data;
              bs_ctrl <= win_shamt;
            end
          end
        end
        // Stage p1 -> p2: shifter result into the response register
        ST_EXEC: begin
          rsp_data  <= bs_out;
          rsp_id    <= id_p1;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
module tb_barrel_shift_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SW   = 3;
  localparam int IDW  = 2;
`ifdef BS_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*SW-1:0] req_shamt;
  logic [DW-1:0]     bs_in;
  logic [SW-1:0]     bs_ctrl;
  logic [DW-1:0]     bs_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [IDW-1:0]    rsp_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for barrel_shifter_8bit: rotate left by ctrl.
  logic [15:0] rot2;
  assign rot2   = {bs_in, bs_in} << bs_ctrl;
  assign bs_out = rot2[15:8];

  barrel_shift_arbiter #(
    .NREQ (NREQ), .DW (DW), .SW (SW), .IDW (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .bs_in     (bs_in),
    .bs_ctrl   (bs_ctrl),
    .bs_out    (bs_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Reference rotation: one bit at a time.
  function automatic logic [7:0] ref_rotl(input logic [7:0] x, input int s);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < s; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [2:0] s);
    req_valid[i]          = v;
    req_data[i*DW +: DW]  = d;
    req_shamt[i*SW +: SW] = s;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (bs_in !== 8'h00) begin failures++; $display("FAIL reset_bs_in got=%h exp=00", bs_in); end
    checks++; if (bs_ctrl !== 3'd0) begin failures++; $display("FAIL reset_bs_ctrl got=%0d exp=0", bs_ctrl); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 8'h80, 3'd4);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_pulse got=%b exp=0000", req_ready); end
    checks++; if (bs_in !== 8'h80) begin failures++; $display("FAIL single_bs_in got=%h exp=80", bs_in); end
    checks++; if (bs_ctrl !== 3'd4) begin failures++; $display("FAIL single_bs_ctrl got=%0d exp=4", bs_ctrl); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== ref_rotl(8'h80, 4)) begin failures++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, ref_rotl(8'h80, 4)); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_all_four();
    int ord;
    logic [NREQ-1:0] exp_rdy;
    reset_pulse();
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0)
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i + 1), 3'(i + 1));
      #1;
      ord     = (c / 3) % NREQ;
      exp_rdy = (c % 3 == 0) ? (4'b0001 << ord) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (c % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=1", c, rsp_valid); end
        checks++; if (rsp_id !== 2'(ord)) begin failures++; $display("FAIL rr_rsp_id c=%0d got=%0d exp=%0d", c, rsp_id, ord); end
        checks++; if (rsp_data !== ref_rotl(8'(ord + 1), ord + 1)) begin failures++; $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, rsp_data, ref_rotl(8'(ord + 1), ord + 1)); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_rsp_idle c=%0d got=%b exp=0", c, rsp_valid); end
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_back_to_back_stall();
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 8'hFF, 3'd7);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    @(negedge clk);
    set_req(2, 1'b0, 8'h00, 3'd0);
    set_req(1, 1'b1, 8'h11, 3'd1);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_exec_ready got=%b exp=0000", req_ready); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid s=%0d got=%b exp=1", s, rsp_valid); end
      checks++; if (rsp_data !== ref_rotl(8'hFF, 7)) begin failures++; $display("FAIL bp_hold_data s=%0d got=%h exp=%h", s, rsp_data, ref_rotl(8'hFF, 7)); end
      checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL bp_hold_id s=%0d got=%0d exp=2", s, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready s=%0d got=%b exp=0000", s, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    set_req(1, 1'b1, 8'h33, 3'd2);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmo_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 3'd0);
    rst_n = 1'b0;
    #1;
    checks++; if (bs_in !== 8'h00) begin failures++; $display("FAIL rmo_bs_in got=%h exp=00", bs_in); end
    checks++; if (bs_ctrl !== 3'd0) begin failures++; $display("FAIL rmo_bs_ctrl got=%0d exp=0", bs_ctrl); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL rmo_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL rmo_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmo_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmo_no_rsp got=%b exp=0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 8'h0F, 3'd1);
    set_req(2, 1'b1, 8'hF0, 3'd1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmo_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rmo_after_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL rmo_after_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== ref_rotl(8'h0F, 1)) begin failures++; $display("FAIL rmo_after_data got=%h exp=%h", rsp_data, ref_rotl(8'h0F, 1)); end
  endtask

  task automatic test_zero_shift();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 8'h5A, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL zero_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 3'd0);
    #1;
`ifdef BS_ARB_ZERO_BYPASS_EN
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL zero_lat1_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 8'h5A) begin failures++; $display("FAIL zero_lat1_data got=%h exp=5a", rsp_data); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL zero_lat1_id got=%0d exp=1", rsp_id); end
`else
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL zero_lat2_early got=%b exp=0", rsp_valid); end
    checks++; if (bs_in !== 8'h5A) begin failures++; $display("FAIL zero_bs_in got=%h exp=5a", bs_in); end
    checks++; if (bs_ctrl !== 3'd0) begin failures++; $display("FAIL zero_bs_ctrl got=%0d exp=0", bs_ctrl); end
`endif
    @(negedge clk);
    #1;
`ifdef BS_ARB_ZERO_BYPASS_EN
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL zero_lat1_drop got=%b exp=0", rsp_valid); end
`else
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL zero_lat2_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 8'h5A) begin failures++; $display("FAIL zero_lat2_data got=%h exp=5a", rsp_data); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL zero_lat2_id got=%0d exp=1", rsp_id); end
`endif
    @(negedge clk);
  endtask

  // Transaction-level model: at most one op outstanding; it is accepted only
  // while nothing is outstanding, and appears on the response channel a fixed
  // latency later until handshaken.
  task automatic test_random();
    int   last, since, lat, win, acc, sh;
    bit   busy, exp_vld;
    logic [7:0] exp_d, dat;
    logic [1:0] exp_id;
    logic [NREQ-1:0] exp_rdy;
    reset_pulse();
    last = NREQ - 1; busy = 1'b0; since = 0; lat = 2; acc = -1;
    exp_d = '0; exp_id = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (i == acc || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'b1, 8'($urandom), 3'($urandom_range(0, 7)));
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      if (!busy)
        for (int k = 1; k <= NREQ; k++)
          if (win < 0 && req_valid[(last + k) % NREQ]) win = (last + k) % NREQ;
      exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      exp_vld = busy && (since >= lat);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_vld) begin failures++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_vld); end
      if (exp_vld) begin
        checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, exp_d); end
        checks++; if (rsp_id !== exp_id) begin failures++; $display("FAIL rnd_rsp_id c=%0d got=%0d exp=%0d", c, rsp_id, exp_id); end
      end
      acc = -1;
      if (exp_vld && rsp_ready) begin
        busy = 1'b0;
      end else if (win >= 0) begin
        busy   = 1'b1;
        since  = 0;
        acc    = win;
        last   = win;
        dat    = req_data[win*DW +: DW];
        sh     = int'(req_shamt[win*SW +: SW]);
        lat    = (BYP && sh == 0) ? 1 : 2;
        exp_d  = ref_rotl(dat, sh);
        exp_id = 2'(win);
      end
      if (busy) since++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back_stall();
    test_reset_midop();
    test_zero_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
